// File: rtl/sync_fifo_width_conv.sv
// Single-clock FIFO that packs narrow writes into wide words or unpacks wide
// writes into narrow reads. Storage is in wide words; the read side is first-word-fall-through.
module sync_fifo_width_conv #(
  parameter  int P_DATA_I_MSB = 7,
  parameter  int P_DATA_O_MSB = 31,
  parameter  int P_DEPTH      = 16,
  parameter  int P_AFULL      = 12,
  parameter  int P_AEMPTY     = 2,
  localparam int WI = P_DATA_I_MSB + 1,
  localparam int WO = P_DATA_O_MSB + 1,
  localparam int WW = (WI > WO) ? WI : WO,
  localparam int WN = (WI > WO) ? WO : WI,
  localparam int R  = WW / WN,
  localparam int UW = $clog2(R) + 1,
  localparam int AW = $clog2(P_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_inc,
  input  logic [WI-1:0] i_wr_data,
  input  logic          i_wr_last,
  output logic          o_wr_full,
  input  logic          i_rd_inc,
  output logic [WO-1:0] o_rd_data,
  output logic [UW-1:0] o_rd_units,
  output logic          o_rd_last,
  output logic          o_rd_empty,
  output logic [AW:0]   o_level,
  output logic          o_almost_full,
  output logic          o_almost_empty
);
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [LW-1:0] LANE_ONE = LW'(1);
  localparam logic [LW-1:0] LANE_TOP = LW'(R - 1);

  if (WW % WN != 0) begin : g_bad_ratio
    $error("sync_fifo_width_conv: wider width must be an integer multiple of the narrower");
  end
  if (P_DEPTH < 2 || (P_DEPTH & (P_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_width_conv: P_DEPTH must be a power of 2 and >= 2");
  end

  logic [AW:0]   wr_ptr, rd_ptr, level;
  logic [WW-1:0] mem [P_DEPTH];
  logic [WW-1:0] head, commit_word;
  logic          empty, full, wr_ok, rd_ok, commit, pop;

  // Extra wrap bit distinguishes full from empty when the addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;
  assign wr_ok = i_wr_inc && !full;
  assign rd_ok = i_rd_inc && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign o_wr_full      = full;
  assign o_rd_empty     = empty;
  assign o_level        = level;
  assign o_almost_full  = (level >= (AW+1)'(P_AFULL));
  assign o_almost_empty = (level <= (AW+1)'(P_AEMPTY));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (commit) mem[wr_ptr[AW-1:0]] <= commit_word;
  end

  if (WO > WI) begin : g_pack
    logic [LW-1:0] wr_lane;
    logic [WW-1:0] pk_word, pk_next;
    logic [UW-1:0] cnt_mem [P_DEPTH];

    // Lanes not yet written stay zero, so a short commit carries zeros above.
    always_comb begin
      pk_next = pk_word;
      pk_next[wr_lane*WI +: WI] = i_wr_data;
    end

    assign commit      = wr_ok && ((wr_lane == LANE_TOP) || i_wr_last);
    assign commit_word = pk_next;
    assign pop         = rd_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        wr_lane <= '0;
        pk_word <= '0;
      end else if (wr_ok) begin
        if (commit) begin
          wr_lane <= '0;
          pk_word <= '0;
        end else begin
          wr_lane <= wr_lane + LANE_ONE;
          pk_word <= pk_next;
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (commit) cnt_mem[wr_ptr[AW-1:0]] <= UW'(wr_lane) + UW'(1);
    end

    assign o_rd_data  = head;
    assign o_rd_units = empty ? '0 : cnt_mem[rd_ptr[AW-1:0]];
    assign o_rd_last  = 1'b0;
  end else begin : g_unpack
    logic [LW-1:0] rd_lane;
    logic          unused_wr_last;

    assign unused_wr_last = i_wr_last;
    assign commit         = wr_ok;
    assign commit_word    = i_wr_data;
    assign pop            = rd_ok && (rd_lane == LANE_TOP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   rd_lane <= '0;
      else if (rd_ok) rd_lane <= (rd_lane == LANE_TOP) ? '0 : rd_lane + LANE_ONE;
    end

    assign o_rd_data  = head[rd_lane*WO +: WO];
    assign o_rd_units = empty ? '0 : UW'(1);
    assign o_rd_last  = (rd_lane == LANE_TOP) && !empty;
  end

endmodule

// File: tb/tb_sync_fifo_width_conv.sv
// Directed bench: a pack (8->32) and an unpack (32->8) instance, both depth 4.
module tb_sync_fifo_width_conv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // pack instance
  logic        pk_wr_inc = 0, pk_wr_last = 0, pk_rd_inc = 0;
  logic [7:0]  pk_wr_data = '0;
  logic        pk_full, pk_last, pk_empty, pk_afull, pk_aempty;
  logic [31:0] pk_data;
  logic [2:0]  pk_units, pk_level;

  // unpack instance
  logic        up_wr_inc = 0, up_wr_last = 0, up_rd_inc = 0;
  logic [31:0] up_wr_data = '0;
  logic        up_full, up_last, up_empty, up_afull, up_aempty;
  logic [7:0]  up_data;
  logic [2:0]  up_units, up_level;

  logic [7:0] q[$];

  sync_fifo_width_conv #(.P_DATA_I_MSB(7), .P_DATA_O_MSB(31), .P_DEPTH(4),
                         .P_AFULL(3), .P_AEMPTY(1)) u_pk (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_inc(pk_wr_inc), .i_wr_data(pk_wr_data),
    .i_wr_last(pk_wr_last), .o_wr_full(pk_full), .i_rd_inc(pk_rd_inc),
    .o_rd_data(pk_data), .o_rd_units(pk_units), .o_rd_last(pk_last),
    .o_rd_empty(pk_empty), .o_level(pk_level), .o_almost_full(pk_afull),
    .o_almost_empty(pk_aempty));

  sync_fifo_width_conv #(.P_DATA_I_MSB(31), .P_DATA_O_MSB(7), .P_DEPTH(4),
                         .P_AFULL(3), .P_AEMPTY(1)) u_up (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_inc(up_wr_inc), .i_wr_data(up_wr_data),
    .i_wr_last(up_wr_last), .o_wr_full(up_full), .i_rd_inc(up_rd_inc),
    .o_rd_data(up_data), .o_rd_units(up_units), .o_rd_last(up_last),
    .o_rd_empty(up_empty), .o_level(up_level), .o_almost_full(up_afull),
    .o_almost_empty(up_aempty));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pk_wr(input logic [7:0] d, input logic last);
    pk_wr_inc = 1; pk_wr_data = d; pk_wr_last = last;
    tick();
    pk_wr_inc = 0; pk_wr_last = 0;
  endtask

  task automatic pk_pop();
    pk_rd_inc = 1;
    tick();
    pk_rd_inc = 0;
  endtask

  task automatic up_wr(input logic [31:0] d);
    up_wr_inc = 1; up_wr_data = d;
    tick();
    up_wr_inc = 0;
  endtask

  task automatic up_pop();
    up_rd_inc = 1;
    tick();
    up_rd_inc = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pk empty"},  32'(pk_empty),  32'd1);
    chk({tag, " pk full"},   32'(pk_full),   32'd0);
    chk({tag, " pk level"},  32'(pk_level),  32'd0);
    chk({tag, " pk afull"},  32'(pk_afull),  32'd0);
    chk({tag, " pk aempty"}, 32'(pk_aempty), 32'd1);
    chk({tag, " pk units"},  32'(pk_units),  32'd0);
    chk({tag, " pk last"},   32'(pk_last),   32'd0);
    chk({tag, " up empty"},  32'(up_empty),  32'd1);
    chk({tag, " up level"},  32'(up_level),  32'd0);
    chk({tag, " up units"},  32'(up_units),  32'd0);
    chk({tag, " up last"},   32'(up_last),   32'd0);
  endtask

  initial begin
    logic [31:0] up_words [2];
    logic [7:0]  exp_b;
    logic        do_rd;
    int          k;

    // reset state
    #2;
    chk_reset_vals("reset");
    tick();
    rst_n = 1;
    tick();

    // 1: full pack of four units
    pk_wr(8'h11, 0); pk_wr(8'h22, 0); pk_wr(8'h33, 0);
    chk("t1 partial invisible", 32'(pk_empty), 32'd1);
    chk("t1 partial level", 32'(pk_level), 32'd0);
    pk_wr(8'h44, 0);
    chk("t1 data",   pk_data, 32'h44332211);
    chk("t1 units",  32'(pk_units), 32'd4);
    chk("t1 level",  32'(pk_level), 32'd1);
    chk("t1 empty",  32'(pk_empty), 32'd0);
    chk("t1 aempty", 32'(pk_aempty), 32'd1);
    pk_pop();
    chk("t1 drained", 32'(pk_empty), 32'd1);

    // 2: partial commit via i_wr_last, then next word starts at lane 0
    pk_wr(8'hAA, 0); pk_wr(8'hBB, 1);
    chk("t2 data",  pk_data, 32'h0000BBAA);
    chk("t2 units", 32'(pk_units), 32'd2);
    pk_pop();
    pk_wr(8'hCC, 1);
    chk("t2 lane0 data",  pk_data, 32'h000000CC);
    chk("t2 lane0 units", 32'(pk_units), 32'd1);
    pk_pop();
    chk("t2 empty", 32'(pk_empty), 32'd1);

    // 3: unpack, including lane rollover across two words
    up_wr(32'hDDCCBBAA);
    chk("t3 level", 32'(up_level), 32'd1);
    chk("t3 units", 32'(up_units), 32'd1);
    chk("t3 b0", 32'(up_data), 32'hAA); chk("t3 last0", 32'(up_last), 32'd0);
    up_pop();
    chk("t3 b1", 32'(up_data), 32'hBB); chk("t3 last1", 32'(up_last), 32'd0);
    up_pop();
    chk("t3 b2", 32'(up_data), 32'hCC); chk("t3 last2", 32'(up_last), 32'd0);
    up_pop();
    chk("t3 b3", 32'(up_data), 32'hDD); chk("t3 last3", 32'(up_last), 32'd1);
    chk("t3 level before pop", 32'(up_level), 32'd1);
    up_pop();
    chk("t3 empty", 32'(up_empty), 32'd1);
    chk("t3 level0", 32'(up_level), 32'd0);
    chk("t3 last after", 32'(up_last), 32'd0);
    up_words[0] = 32'h44332211;
    up_words[1] = 32'h88776655;
    up_wr(up_words[0]); up_wr(up_words[1]);
    chk("t3 two words level", 32'(up_level), 32'd2);
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) begin
        exp_b = 8'(up_words[w] >> (8*b));
        chk($sformatf("t3 w%0d b%0d", w, b), 32'(up_data), 32'(exp_b));
        chk($sformatf("t3 w%0d last%0d", w, b), 32'(up_last), (b == 3) ? 32'd1 : 32'd0);
        up_pop();
      end
    end
    chk("t3 two words empty", 32'(up_empty), 32'd1);

    // 4: fill to full, reject extra write, pop while full
    pk_wr(8'h01, 1); pk_wr(8'h02, 1);
    chk("t4 afull at 2", 32'(pk_afull), 32'd0);
    pk_wr(8'h03, 1);
    chk("t4 afull at 3", 32'(pk_afull), 32'd1);
    chk("t4 full at 3",  32'(pk_full),  32'd0);
    pk_wr(8'h04, 1);
    chk("t4 full",  32'(pk_full),  32'd1);
    chk("t4 level", 32'(pk_level), 32'd4);
    pk_wr(8'h55, 1);
    chk("t4 reject level", 32'(pk_level), 32'd4);
    chk("t4 reject head",  pk_data, 32'h00000001);
    pk_wr_inc = 1; pk_wr_data = 8'h66; pk_wr_last = 1; pk_rd_inc = 1;
    tick();
    pk_wr_inc = 0; pk_wr_last = 0; pk_rd_inc = 0;
    chk("t4 pop while full level", 32'(pk_level), 32'd3);
    chk("t4 full drops", 32'(pk_full), 32'd0);
    chk("t4 head after pop", pk_data, 32'h00000002);
    pk_wr(8'h66, 1);
    chk("t4 refill full", 32'(pk_full), 32'd1);
    for (int i = 0; i < 4; i++) q.push_back((i < 3) ? 8'(i + 2) : 8'h66);
    while (q.size() > 0) begin
      chk("t4 drain", pk_data, 32'(q.pop_front()));
      pk_pop();
    end
    chk("t4 drained", 32'(pk_empty), 32'd1);

    // 5: wrap-around with simultaneous commit+pop, checked against a queue
    for (int i = 0; i < 10; i++) begin
      do_rd = (i % 2 == 1);
      pk_wr_inc = 1; pk_wr_data = 8'(8'h10 + i); pk_wr_last = 1; pk_rd_inc = do_rd;
      tick();
      pk_wr_inc = 0; pk_wr_last = 0; pk_rd_inc = 0;
      // model: full/empty judged on the pre-edge occupancy
      k = q.size();
      if (do_rd && k > 0) void'(q.pop_front());
      if (k < 4) q.push_back(8'(8'h10 + i));
      chk($sformatf("t5 level %0d", i), 32'(pk_level), 32'(q.size()));
      chk($sformatf("t5 empty %0d", i), 32'(pk_empty), 32'(q.size() == 0));
      chk($sformatf("t5 full %0d", i),  32'(pk_full),  32'(q.size() == 4));
      if (q.size() > 0) chk($sformatf("t5 head %0d", i), pk_data, 32'(q[0]));
    end
    while (q.size() > 0) begin
      chk("t5 drain", pk_data, 32'(q.pop_front()));
      chk("t5 drain units", 32'(pk_units), 32'd1);
      pk_pop();
    end
    chk("t5 final empty", 32'(pk_empty), 32'd1);

    // 6: reset mid-stream discards words, partial unit and read lane
    pk_wr(8'hA1, 1); pk_wr(8'hA2, 1); pk_wr(8'hA3, 0);
    up_wr(32'h0D0C0B0A); up_pop();
    chk("t6 pre level", 32'(pk_level), 32'd2);
    chk("t6 pre up lane1", 32'(up_data), 32'h0B);
    rst_n = 0;
    #1;
    chk_reset_vals("t6 reset");
    tick();
    rst_n = 1;
    tick();
    pk_wr(8'hB1, 0); pk_wr(8'hB2, 1);
    chk("t6 pack lane0", pk_data, 32'h0000B2B1);
    chk("t6 pack units", 32'(pk_units), 32'd2);
    chk("t6 pack level", 32'(pk_level), 32'd1);
    up_wr(32'h44332211);
    chk("t6 unpack lane0", 32'(up_data), 32'h11);
    chk("t6 unpack level", 32'(up_level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
